// File: rtl/led_field_manager.sv
// LED field manager: holds the lit-LED field fed by the spawner, scores button hits/misses,
// and runs the IDLE/PLAY/OVER round state machine including the OVER blink display.
module led_field_manager #(
    parameter int LED_COUNT    = 18,
    parameter int IDX_W        = $clog2(LED_COUNT),
    parameter int SCORE_W      = 16,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_request,
    input  logic [IDX_W-1:0]     led_index,
    input  logic                 game_over,
    input  logic                 start,
    input  logic [LED_COUNT-1:0] btn,
    output logic [LED_COUNT-1:0] leds,
    output logic [IDX_W:0]       active_led_count,
    output logic [SCORE_W-1:0]   score,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 dup_pulse,
    output logic [1:0]           state
);
    localparam int SUM_W   = SCORE_W + IDX_W + 2;
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [IDX_W:0]          LED_LIMIT  = (IDX_W+1)'(LED_COUNT);
    localparam logic [BLINK_W-1:0]      BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic signed [SUM_W-1:0] SCORE_MAX  = {{(IDX_W+2){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [LED_COUNT-1:0] field_q, field_d;
    logic [LED_COUNT-1:0] leds_q, leds_d;
    logic [IDX_W:0]       count_q, count_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 hit_q, hit_d, miss_q, miss_d, dup_q, dup_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [LED_COUNT-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [LED_COUNT-1:0] press_q, press_d;

    logic [LED_COUNT-1:0]    hit_vec, miss_vec, req_vec;
    logic                    req_in_range, req_blocked;
    logic signed [SUM_W-1:0] score_sum;

    function automatic logic [IDX_W:0] popcount(input logic [LED_COUNT-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        // Edge detect output is registered so a press lands 3 clocks after the button rise.
        sync1_d = btn;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        press_d = sync2_q & ~sync3_q;

        hit_vec      = press_q & field_q;
        miss_vec     = press_q & ~field_q;
        req_in_range = ({1'b0, led_index} < LED_LIMIT);
        req_vec      = (led_request && req_in_range) ? (LED_COUNT'(1) << led_index) : '0;
        // A press on the same lit LED as the request counts as a hit, not a duplicate.
        req_blocked  = led_request && (!req_in_range || (|(req_vec & field_q & ~press_q)));
        score_sum    = $signed({{(IDX_W+2){1'b0}}, score_q})
                     + $signed({{(SCORE_W+1){1'b0}}, popcount(hit_vec)})
                     - $signed({{(SCORE_W+1){1'b0}}, popcount(miss_vec)});

        state_d       = state_q;
        field_d       = field_q;
        score_d       = score_q;
        hit_d         = 1'b0;
        miss_d        = 1'b0;
        dup_d         = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        case (state_q)
            ST_IDLE: begin
                field_d = '0;
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                field_d = (field_q & ~hit_vec) | req_vec;
                hit_d   = |hit_vec;
                miss_d  = |miss_vec;
                dup_d   = req_blocked;
                if (score_sum < 0) begin
                    score_d = '0;
                end else if (score_sum > SCORE_MAX) begin
                    score_d = '1;
                end else begin
                    score_d = score_sum[SCORE_W-1:0];
                end
                if (game_over) begin
                    state_d       = ST_OVER;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b0;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_IDLE;
                    field_d = '0;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                field_d = '0;
            end
        endcase

        count_d = popcount(field_d);
        leds_d  = (state_d == ST_OVER && !blink_phase_d) ? '0 : field_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            field_q       <= '0;
            leds_q        <= '0;
            count_q       <= '0;
            score_q       <= '0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            dup_q         <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            press_q       <= '0;
        end else begin
            state_q       <= state_d;
            field_q       <= field_d;
            leds_q        <= leds_d;
            count_q       <= count_d;
            score_q       <= score_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            dup_q         <= dup_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            press_q       <= press_d;
        end
    end

    assign leds             = leds_q;
    assign active_led_count = count_q;
    assign score            = score_q;
    assign hit_pulse        = hit_q;
    assign miss_pulse       = miss_q;
    assign dup_pulse        = dup_q;
    assign state            = state_q;
endmodule

// File: tb/tb_led_field_manager.sv
// Bench for led_field_manager: directed round walkthrough plus random play, checked every
// cycle against a behavioural model of the field, score, buttons and blink display.
module tb_led_field_manager;
    localparam int N  = 18;
    localparam int IW = 5;
    localparam int SW = 16;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          led_request = 1'b0;
    logic [IW-1:0] led_index = '0;
    logic          game_over = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  btn = '0;
    logic [N-1:0]  leds;
    logic [IW:0]   active_led_count;
    logic [SW-1:0] score;
    logic          hit_pulse, miss_pulse, dup_pulse;
    logic [1:0]    state;

    led_field_manager #(
        .LED_COUNT(N), .IDX_W(IW), .SCORE_W(SW), .BLINK_CYCLES(BC)
    ) dut (
        .clk(clk), .rst(rst), .led_request(led_request), .led_index(led_index),
        .game_over(game_over), .start(start), .btn(btn), .leds(leds),
        .active_led_count(active_led_count), .score(score), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .dup_pulse(dup_pulse), .state(state)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    bit           chk_en = 0;
    logic [N-1:0] btn_hold = '0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: mode 0 idle, 1 play, 2 over; btn history drives press detection.
    logic [N-1:0] m_field;
    logic [N-1:0] m_hist [4];
    int           m_score, m_mode, m_over_cycles;
    bit           m_hit, m_miss, m_dup;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] press, old;
        int hits, misses, sum;
        if (rst) begin
            m_field = '0; m_score = 0; m_mode = 0; m_over_cycles = 0;
            m_hit = 0; m_miss = 0; m_dup = 0;
            for (int k = 0; k < 4; k++) m_hist[k] = '0;
        end else begin
            // Press lands when btn was high 3 edges back and low 4 edges back.
            press = m_hist[2] & ~m_hist[3];
            for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = btn;
            m_hit = 0; m_miss = 0; m_dup = 0;
            case (m_mode)
                0: begin
                    m_field = '0;
                    if (start) begin m_mode = 1; m_score = 0; end
                end
                1: begin
                    old    = m_field;
                    hits   = $countones(press & old);
                    misses = $countones(press & ~old);
                    m_field = old & ~press;
                    if (led_request) begin
                        if (int'(led_index) >= N) m_dup = 1;
                        else if (old[led_index] && !press[led_index]) m_dup = 1;
                        else m_field[led_index] = 1'b1;
                    end
                    sum = m_score + hits - misses;
                    m_score = (sum < 0) ? 0 : (sum > 65535) ? 65535 : sum;
                    m_hit  = hits > 0;
                    m_miss = misses > 0;
                    if (game_over) begin m_mode = 2; m_over_cycles = 0; end
                end
                default: begin
                    if (start) begin m_mode = 0; m_field = '0; end
                    else m_over_cycles++;
                end
            endcase
        end
    end

    function automatic logic [N-1:0] exp_leds();
        if (m_mode == 2 && ((m_over_cycles / BC) % 2) == 0) return '0;
        return m_field;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("leds", leds, exp_leds());
            chk("count", active_led_count, $countones(m_field));
            chk("score", score, m_score);
            chk("hit_pulse", hit_pulse, m_hit);
            chk("miss_pulse", miss_pulse, m_miss);
            chk("dup_pulse", dup_pulse, m_dup);
            chk("state", state, m_mode);
        end
    end

    task automatic tick(input bit req, input int idx, input bit go, input bit st);
        @(negedge clk);
        led_request = req;
        led_index   = idx[IW-1:0];
        game_over   = go;
        start       = st;
        btn         = btn_hold;
        @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input logic [N-1:0] mask, input bit req, input int idx);
        btn_hold = mask;
        repeat (3) tick(0, 0, 0, 0);
        chk("no_early_pulse", hit_pulse | miss_pulse, 0);
        tick(req, idx, 0, 0);
    endtask

    task automatic release_btn();
        btn_hold = '0;
        repeat (4) tick(0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("reset_state", state, 0);
        chk("reset_leds", leds, 0);
        chk("reset_score", score, 0);

        tick(0, 0, 0, 1);
        chk("start_play", state, 1);
        tick(1, 3, 0, 0);
        chk("req3_leds", leds, 18'h8);
        chk("req3_count", active_led_count, 1);
        chk("req3_dup", dup_pulse, 0);
        tick(1, 3, 0, 0);
        chk("dup_lit", dup_pulse, 1);
        chk("dup_lit_count", active_led_count, 1);
        tick(1, 20, 0, 0);
        chk("dup_range", dup_pulse, 1);
        chk("dup_range_leds", leds, 18'h8);

        press_btn(18'h8, 0, 0);
        chk("hit3_pulse", hit_pulse, 1);
        chk("hit3_leds", leds, 0);
        chk("hit3_score", score, 1);
        repeat (3) begin
            tick(0, 0, 0, 0);
            chk("held_no_hit", hit_pulse, 0);
        end
        release_btn();

        press_btn(18'h20, 0, 0);
        chk("miss5_pulse", miss_pulse, 1);
        chk("miss5_score", score, 0);
        release_btn();
        press_btn(18'h20, 0, 0);
        chk("miss_floor", score, 0);
        release_btn();

        tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 2, 0, 0);
        press_btn(18'h7, 0, 0);
        chk("tri_hit_score", score, 3);
        chk("tri_hit_count", active_led_count, 0);
        chk("tri_hit_pulse", hit_pulse, 1);
        release_btn();

        tick(1, 7, 0, 0);
        press_btn(18'h80, 1, 7);
        chk("hitreq_score", score, 4);
        chk("hitreq_leds", leds, 18'h80);
        chk("hitreq_dup", dup_pulse, 0);
        release_btn();

        tick(1, 9, 0, 0);
        tick(0, 0, 1, 1);
        chk("over_state", state, 2);
        chk("over_blank", leds, 0);
        for (int k = 1; k <= 8; k++) begin
            btn_hold = (k % 2 == 1) ? '1 : '0;
            tick(1, k, 0, 0);
            if (k == 4) chk("blink_on", leds, 18'h280);
            if (k == 8) chk("blink_off", leds, 0);
        end
        btn_hold = '0;
        tick(0, 0, 0, 1);
        chk("over_idle", state, 0);
        chk("idle_leds", leds, 0);
        chk("score_held", score, 4);
        tick(0, 0, 0, 1);
        chk("restart_score", score, 0);

        tick(1, 4, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_leds", leds, 0);
        chk("async_rst_count", active_led_count, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_hold[$urandom_range(0, N-1)] ^= 1'b1;
            tick($urandom_range(0, 2) == 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
